// File: rtl/dsp_arb_pkg.sv
// dsp_arb_pkg: shared constants, id sizing helper and tag type for dsp_add_arbiter
package dsp_arb_pkg;

   localparam int DSP_ADD_LAT_DEFAULT = 2;

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic        valid;
      logic [15:0] id;
   } tag_t;

endpackage

// File: rtl/dsp_add.sv
// dsp_add: pipelined unsigned adder, y = a + b after lat clock cycles (no reset on data)
module dsp_add #(
   parameter int width = 24,
   parameter int lat   = 2
) (
   input  logic             clock,
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   output logic [width-1:0] y
);

   logic [width-1:0] pipe [lat];

   // sum in the first stage, then delay through the remaining stages
   always_ff @(posedge clock) begin
      pipe[0] <= a + b;
      for (int i = 1; i < lat; i++) pipe[i] <= pipe[i-1];
   end

   assign y = pipe[lat-1];

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant starting at ptr, ptr moves past each winner
module rr_arbiter
   import dsp_arb_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NREQ-1:0]               req,
   output logic [NREQ-1:0]               grant,
   output logic [id_width(NREQ)-1:0]     grant_id,
   output logic                          grant_valid
);

   localparam int IW = id_width(NREQ);

   logic [IW-1:0] ptr;

   // first requester at or after ptr, wrapping; nothing granted while in reset
   always_comb begin
      grant       = '0;
      grant_id    = '0;
      grant_valid = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (reset && !grant_valid && req[(int'(ptr) + k) % NREQ]) begin
            grant[(int'(ptr) + k) % NREQ] = 1'b1;
            grant_id    = IW'((int'(ptr) + k) % NREQ);
            grant_valid = 1'b1;
         end
      end
   end

   // pointer advances to the requester after the winner, holds when idle
   always_ff @(posedge clock) begin
      if (!reset)
         ptr <= '0;
      else if (grant_valid)
         ptr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
   end

endmodule

// File: rtl/dsp_add_arbiter.sv
// dsp_add_arbiter: NREQ requesters share one pipelined dsp_add; optional DSP_ADD_ARBITER_STATS_EN adds grant counters
module dsp_add_arbiter
   import dsp_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 24,
   parameter int DSP_LAT = DSP_ADD_LAT_DEFAULT
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NREQ-1:0]               req_valid,
   output logic [NREQ-1:0]               req_ready,
   input  logic [NREQ*WIDTH-1:0]         req_a,
   input  logic [NREQ*WIDTH-1:0]         req_b,
   output logic                          rsp_valid,
   output logic [id_width(NREQ)-1:0]     rsp_id,
   output logic [WIDTH-1:0]              rsp_y,
   output logic                          busy
`ifdef DSP_ADD_ARBITER_STATS_EN
   ,
   output logic [NREQ*32-1:0]            stat_grants
`endif
);

   localparam int IW = id_width(NREQ);

   logic [IW-1:0]    gnt_id;
   logic             gnt_v;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic             iss_v;
   logic [IW-1:0]    iss_id;
   logic [WIDTH-1:0] iss_a, iss_b;
   tag_t             tag [DSP_LAT];
   logic             unused_id_hi;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clock       (clock),
      .reset       (reset),
      .req         (req_valid),
      .grant       (req_ready),
      .grant_id    (gnt_id),
      .grant_valid (gnt_v)
   );

   // operand mux driven by the one-hot grant
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            sel_a = req_a[i*WIDTH +: WIDTH];
            sel_b = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // issue valid: only this and the tag valids need reset
   always_ff @(posedge clock) begin
      if (!reset)
         iss_v <= 1'b0;
      else
         iss_v <= gnt_v;
   end

   // issue data feeds the adder the cycle after the transfer
   always_ff @(posedge clock) begin
      iss_a  <= sel_a;
      iss_b  <= sel_b;
      iss_id <= gnt_id;
   end

   dsp_add #(.width(WIDTH), .lat(DSP_LAT)) u_add (
      .clock (clock),
      .a     (iss_a),
      .b     (iss_b),
      .y     (rsp_y)
   );

   // tag shift register tracks the adder pipeline so stale sums never look valid
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < DSP_LAT; i++) tag[i] <= '0;
      end else begin
         tag[0] <= {iss_v, 16'(iss_id)};
         for (int i = 1; i < DSP_LAT; i++) tag[i] <= tag[i-1];
      end
   end

   // busy while anything sits in the issue register or the tag pipeline
   always_comb begin
      busy = iss_v;
      for (int i = 0; i < DSP_LAT; i++) busy = busy | tag[i].valid;
   end

   assign rsp_valid    = tag[DSP_LAT-1].valid;
   assign rsp_id       = tag[DSP_LAT-1].id[IW-1:0];
   assign unused_id_hi = ^tag[DSP_LAT-1].id[15:IW];

`ifdef DSP_ADD_ARBITER_STATS_EN
   // per-requester saturating transfer counters
   always_ff @(posedge clock) begin
      if (!reset) begin
         stat_grants <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++)
            if (req_ready[i] && stat_grants[i*32 +: 32] != 32'hFFFF_FFFF)
               stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dsp_add_arbiter.sv
// tb_dsp_add_arbiter: directed plus random stimulus against a queue-based reference model
module tb_dsp_add_arbiter;

   localparam int N = 4;
   localparam int W = 24;
   localparam int L = 2;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_y;
   logic           busy;
`ifdef DSP_ADD_ARBITER_STATS_EN
   logic [N*32-1:0] stat_grants;
`endif

   always #5 clock = ~clock;

   dsp_add_arbiter #(.NREQ(N), .WIDTH(W), .DSP_LAT(L)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .busy      (busy)
`ifdef DSP_ADD_ARBITER_STATS_EN
      ,
      .stat_grants (stat_grants)
`endif
   );

   typedef struct {
      int           id;
      logic [W-1:0] y;
      int           due;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          mptr = 0;
   int unsigned gcnt [N];
   logic [N-1:0] last_g = '0;
   logic [N-1:0] pend = '0;
   bit          was_rst = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   // one clock cycle: check outputs mid-cycle against the model, then advance
   task automatic cycle();
      int           g;
      logic [N-1:0] eg;
      @(negedge clock);
      check("busy", 64'(busy), 64'(q.size() != 0));
      if (was_rst) check("rst_id", 64'(rsp_id), 64'd0);
      if (q.size() != 0 && q[0].due == cyc) begin
         check("rsp_valid", 64'(rsp_valid), 64'd1);
         check("rsp_id", 64'(rsp_id), 64'(q[0].id));
         check("rsp_y", 64'(rsp_y), 64'(q[0].y));
         void'(q.pop_front());
      end else begin
         check("rsp_valid", 64'(rsp_valid), 64'd0);
      end
      g  = -1;
      eg = '0;
      if (reset)
         for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
      if (g >= 0) begin
         eg[g] = 1'b1;
         q.push_back('{g, W'(req_a[g*W +: W] + req_b[g*W +: W]), cyc + 1 + L});
         mptr = (g + 1) % N;
         gcnt[g]++;
      end
      check("req_ready", 64'(req_ready), 64'(eg));
      last_g  = eg;
      was_rst = !reset;
      if (!reset) begin
         q.delete();
         mptr = 0;
         foreach (gcnt[i]) gcnt[i] = 0;
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic check_stats();
`ifdef DSP_ADD_ARBITER_STATS_EN
      for (int i = 0; i < N; i++)
         check($sformatf("stat_grants[%0d]", i), 64'(stat_grants[i*32 +: 32]), 64'(gcnt[i]));
`endif
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      foreach (gcnt[i]) gcnt[i] = 0;
      reset = 1'b0;
      @(posedge clock);
      #1;
      repeat (2) cycle();
      reset = 1'b1;
      // single request with two's-complement operands
      set_req(0, 24'hFFFFFF, 24'd16);
      req_valid = 4'b0001;
      cycle();
      req_valid = '0;
      repeat (4) cycle();
      // all four valid continuously
      for (int i = 0; i < N; i++) set_req(i, W'(i), 24'd10);
      req_valid = '1;
      repeat (8) cycle();
      req_valid = '0;
      repeat (4) cycle();
      // rotation from the pointer
      req_valid = 4'b0010;
      cycle();
      req_valid = 4'b1011;
      repeat (2) cycle();
      req_valid = '0;
      repeat (4) cycle();
      // modular wrap-around on req2
      set_req(2, 24'hFFFFFF, 24'h000002);
      req_valid = 4'b0100;
      cycle();
      req_valid = '0;
      repeat (4) cycle();
      // reset with requests in flight
      req_valid = '1;
      repeat (3) cycle();
      req_valid = '0;
      cycle();
      reset = 1'b0;
      repeat (2) cycle();
      reset = 1'b1;
      req_valid = '1;
      cycle();
      req_valid = '0;
      repeat (4) cycle();
      check_stats();
      // random requesters that hold until granted, occasionally drop, with rare resets
      repeat (2000) begin
         reset = ($urandom_range(199) != 0);
         for (int i = 0; i < N; i++) begin
            if (last_g[i]) pend[i] = 1'b0;
            else if (pend[i] && $urandom_range(15) == 0) pend[i] = 1'b0;
            if (!pend[i] && $urandom_range(2) == 0) begin
               pend[i] = 1'b1;
               set_req(i, W'($urandom), W'($urandom));
            end
         end
         req_valid = pend;
         cycle();
      end
      reset = 1'b1;
      req_valid = '0;
      repeat (6) cycle();
      check("drained", 64'(q.size()), 64'd0);
      check_stats();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
